// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a 4-digit
// common-anode 7-segment display.
//
// The display word is double-buffered. A load strobe captures a new value
// into a pending buffer. In SCAN that value becomes visible at the next
// 3->0 digit wrap. In BLANK it becomes visible on the next cycle.
// At the start of each digit slot, all anodes are held off for GUARD cycles
// to suppress ghosting.
//
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, digits 1..3 stay dark for the whole slot when the digit
//   and every digit to its left are zero and the digit's decimal point is off.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   enable      1 = scan, 0 = display blanked
//   load        1-cycle strobe, captures value_in/dp_in into the pending buffer
//   value_in    four hex nibbles, [3:0] = rightmost digit
//   dp_in       per-digit decimal point, 1 = lit, [0] = rightmost
//   digit_data  nibble for the segment decoder
//   anode       active-low digit enables, [0] = rightmost
//   dp_out      active-low decimal point for the current digit
//   frame_done  1-cycle pulse after each 3->0 digit wrap
module seg7_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DIV_W    = 17,
    parameter int unsigned GUARD    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  digit_data,
    output logic [3:0]  anode,
    output logic        dp_out,
    output logic        frame_done
);

    localparam int unsigned VAL_W = 16;
    localparam int unsigned DIG_N = 4;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] GUARD_CNT = DIV_W'(GUARD);

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   prescaler, prescaler_nxt;
    logic [1:0]         idx, idx_nxt;
    logic [VAL_W-1:0]   disp_val, disp_val_nxt;
    logic [DIG_N-1:0]   disp_dp, disp_dp_nxt;
    logic [VAL_W-1:0]   pend_val, pend_val_nxt;
    logic [DIG_N-1:0]   pend_dp, pend_dp_nxt;
    logic               pending, pending_nxt;
    logic [3:0]         digit_data_nxt;
    logic [3:0]         anode_nxt;
    logic               dp_out_nxt;
    logic               frame_done_nxt;
    logic               tick;
    logic               wrap;
    logic               commit;
    logic               lz_blank;

    // Digit dark due to leading-zero suppression (never digit 0)
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank = 1'b0;
        case (idx)
            2'd1:    lz_blank = (disp_val[15:4]  == 12'h000) && !disp_dp[1];
            2'd2:    lz_blank = (disp_val[15:8]  == 8'h00)   && !disp_dp[2];
            2'd3:    lz_blank = (disp_val[15:12] == 4'h0)    && !disp_dp[3];
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Next state, prescaler/index stepping, buffer commit and output decode
    always_comb begin
        state_nxt      = state;
        prescaler_nxt  = prescaler;
        idx_nxt        = idx;
        disp_val_nxt   = disp_val;
        disp_dp_nxt    = disp_dp;
        pend_val_nxt   = pend_val;
        pend_dp_nxt    = pend_dp;
        pending_nxt    = pending;
        tick           = 1'b0;
        wrap           = 1'b0;
        commit         = 1'b0;
        digit_data_nxt = disp_val[{idx, 2'b00} +: 4];
        anode_nxt      = 4'b1111;
        dp_out_nxt     = 1'b1;

        case (state)
            BLANK: begin
                prescaler_nxt = '0;
                idx_nxt       = '0;
                commit        = pending;
                if (enable) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                dp_out_nxt = ~disp_dp[idx];
                if ((prescaler >= GUARD_CNT) && !lz_blank) begin
                    anode_nxt = ~(4'b0001 << idx);
                end
                if (!enable) begin
                    // Leaving scan discards the slot in progress, so no tick or wrap
                    state_nxt     = BLANK;
                    prescaler_nxt = '0;
                    idx_nxt       = '0;
                end else begin
                    tick   = (prescaler == DIV_LAST);
                    wrap   = tick && (idx == 2'd3);
                    commit = wrap && pending;
                    if (tick) begin
                        prescaler_nxt = '0;
                        idx_nxt       = idx + 2'd1;
                    end else begin
                        prescaler_nxt = prescaler + DIV_W'(1);
                    end
                end
            end
            default: state_nxt = BLANK;
        endcase

        // Commit first, so a load in the same cycle refills the pending buffer
        if (commit) begin
            disp_val_nxt = pend_val;
            disp_dp_nxt  = pend_dp;
            pending_nxt  = 1'b0;
        end
        if (load) begin
            pend_val_nxt = value_in;
            pend_dp_nxt  = dp_in;
            pending_nxt  = 1'b1;
        end

        frame_done_nxt = wrap;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BLANK;
            prescaler  <= '0;
            idx        <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pending    <= 1'b0;
            digit_data <= '0;
            anode      <= 4'b1111;
            dp_out     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            prescaler  <= prescaler_nxt;
            idx        <= idx_nxt;
            disp_val   <= disp_val_nxt;
            disp_dp    <= disp_dp_nxt;
            pend_val   <= pend_val_nxt;
            pend_dp    <= pend_dp_nxt;
            pending    <= pending_nxt;
            digit_data <= digit_data_nxt;
            anode      <= anode_nxt;
            dp_out     <= dp_out_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed, table-driven bench for seg7_scan_ctrl with
// SCAN_DIV=8 and GUARD=1.
// Each table row holds inputs for n cycles. The expected outputs are checked
// after every one of those cycles.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_data;
    logic [3:0]  anode;
    logic        dp_out;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    seg7_scan_ctrl #(.SCAN_DIV(8), .DIV_W(4), .GUARD(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .digit_data (digit_data),
        .anode      (anode),
        .dp_out     (dp_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  an;
        logic [3:0]  dig;
        logic        dpo;
        logic        fd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int n, logic en, logic ld, logic [15:0] val,
                                logic [3:0] dp, logic [3:0] an, logic [3:0] dig,
                                logic dpo, logic fd);
        vec_t v;
        v.n = n; v.en = en; v.ld = ld; v.val = val; v.dp = dp;
        v.an = an; v.dig = dig; v.dpo = dpo; v.fd = fd;
        tbl.push_back(v);
    endfunction

    // One 8-cycle slot, enable held, no load: 1 guard cycle and 7 lit cycles
    function automatic void add_slot(logic [3:0] an, logic [3:0] dig, logic dpo, logic fd);
        add(1, 1'b1, 1'b0, 16'h0, 4'h0, 4'b1111, dig, dpo, 1'b0);
        if (fd) begin
            add(6, 1'b1, 1'b0, 16'h0, 4'h0, an, dig, dpo, 1'b0);
            add(1, 1'b1, 1'b0, 16'h0, 4'h0, an, dig, dpo, 1'b1);
        end else begin
            add(7, 1'b1, 1'b0, 16'h0, 4'h0, an, dig, dpo, 1'b0);
        end
    endfunction

    task automatic check(string name, logic [3:0] an, logic [3:0] dig, logic dpo, logic fd);
        checks++;
        if (anode !== an || digit_data !== dig || dp_out !== dpo || frame_done !== fd) begin
            errors++;
            $display("FAIL %s: got an=%b dig=%h dp=%b fd=%b, want an=%b dig=%h dp=%b fd=%b",
                     name, anode, digit_data, dp_out, frame_done, an, dig, dpo, fd);
        end
    endtask

    task automatic run_vec(vec_t v, string tag);
        for (int c = 0; c < v.n; c++) begin
            enable   = v.en;
            load     = v.ld;
            value_in = v.val;
            dp_in    = v.dp;
            @(posedge clk);
            #1;
            check($sformatf("%s cyc%0d", tag, c), v.an, v.dig, v.dpo, v.fd);
        end
    endtask

    initial begin
        vec_t v;

        reset = 1'b0; enable = 1'b0; load = 1'b0; value_in = '0; dp_in = '0;

        // Frame 1: value 1234, dp on digit 2; loaded while blank, then enabled
        add(1, 1'b0, 1'b1, 16'h1234, 4'b0100, 4'b1111, 4'h0, 1'b1, 1'b0);
        add(1, 1'b1, 1'b0, 16'h0,    4'h0,    4'b1111, 4'h0, 1'b1, 1'b0);
        add_slot(4'b1110, 4'h4, 1'b1, 1'b0);
        add_slot(4'b1101, 4'h3, 1'b1, 1'b0);
        add_slot(4'b1011, 4'h2, 1'b0, 1'b0);
        add_slot(4'b0111, 4'h1, 1'b1, 1'b1);
        // Frame 2: ABCD loaded during digit 1, old value still shown for 2 and 3
        add_slot(4'b1110, 4'h4, 1'b1, 1'b0);
        add(1, 1'b1, 1'b0, 16'h0,    4'h0, 4'b1111, 4'h3, 1'b1, 1'b0);
        add(3, 1'b1, 1'b0, 16'h0,    4'h0, 4'b1101, 4'h3, 1'b1, 1'b0);
        add(1, 1'b1, 1'b1, 16'hABCD, 4'h0, 4'b1101, 4'h3, 1'b1, 1'b0);
        add(3, 1'b1, 1'b0, 16'h0,    4'h0, 4'b1101, 4'h3, 1'b1, 1'b0);
        add_slot(4'b1011, 4'h2, 1'b0, 1'b0);
        add_slot(4'b0111, 4'h1, 1'b1, 1'b1);
        // Frame 3: ABCD; load 1111 mid-frame, then 2222 on the commit tick
        add(1, 1'b1, 1'b0, 16'h0,    4'h0, 4'b1111, 4'hD, 1'b1, 1'b0);
        add(1, 1'b1, 1'b1, 16'h1111, 4'h0, 4'b1110, 4'hD, 1'b1, 1'b0);
        add(6, 1'b1, 1'b0, 16'h0,    4'h0, 4'b1110, 4'hD, 1'b1, 1'b0);
        add_slot(4'b1101, 4'hC, 1'b1, 1'b0);
        add_slot(4'b1011, 4'hB, 1'b1, 1'b0);
        add(1, 1'b1, 1'b0, 16'h0,    4'h0, 4'b1111, 4'hA, 1'b1, 1'b0);
        add(6, 1'b1, 1'b0, 16'h0,    4'h0, 4'b0111, 4'hA, 1'b1, 1'b0);
        add(1, 1'b1, 1'b1, 16'h2222, 4'h0, 4'b0111, 4'hA, 1'b1, 1'b1);
        // Frame 4 shows 1111, frame 5 shows 2222
        add_slot(4'b1110, 4'h1, 1'b1, 1'b0);
        add_slot(4'b1101, 4'h1, 1'b1, 1'b0);
        add_slot(4'b1011, 4'h1, 1'b1, 1'b0);
        add_slot(4'b0111, 4'h1, 1'b1, 1'b1);
        add_slot(4'b1110, 4'h2, 1'b1, 1'b0);
        add_slot(4'b1101, 4'h2, 1'b1, 1'b0);
        add_slot(4'b1011, 4'h2, 1'b1, 1'b0);
        add_slot(4'b0111, 4'h2, 1'b1, 1'b1);
        // Disable mid-slot, load 00F0 while blank, re-enable from digit 0
        add(1, 1'b1, 1'b0, 16'h0,    4'h0, 4'b1111, 4'h2, 1'b1, 1'b0);
        add(3, 1'b1, 1'b0, 16'h0,    4'h0, 4'b1110, 4'h2, 1'b1, 1'b0);
        add(1, 1'b0, 1'b0, 16'h0,    4'h0, 4'b1110, 4'h2, 1'b1, 1'b0);
        add(2, 1'b0, 1'b0, 16'h0,    4'h0, 4'b1111, 4'h2, 1'b1, 1'b0);
        add(1, 1'b0, 1'b1, 16'h00F0, 4'h0, 4'b1111, 4'h2, 1'b1, 1'b0);
        add(1, 1'b0, 1'b0, 16'h0,    4'h0, 4'b1111, 4'h2, 1'b1, 1'b0);
        add(2, 1'b0, 1'b0, 16'h0,    4'h0, 4'b1111, 4'h0, 1'b1, 1'b0);
        add(1, 1'b1, 1'b0, 16'h0,    4'h0, 4'b1111, 4'h0, 1'b1, 1'b0);
        add_slot(4'b1110, 4'h0, 1'b1, 1'b0);
        add_slot(4'b1101, 4'hF, 1'b1, 1'b0);
        add(1, 1'b1, 1'b0, 16'h0,    4'h0, 4'b1111, 4'h0, 1'b1, 1'b0);
        add(3, 1'b1, 1'b0, 16'h0,    4'h0, LZ ? 4'b1111 : 4'b1011, 4'h0, 1'b1, 1'b0);

        // Reset values
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 4'b1111, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            run_vec(tbl[r], $sformatf("row%0d", r));
        end

        // Reset during digit 2 with a load still pending
        enable = 1'b1; load = 1'b1; value_in = 16'h0007; dp_in = 4'h0;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset", 4'b1111, 4'h0, 1'b1, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Pending value lost: blank commit must not pick up 0007
        v.n = 3; v.en = 1'b0; v.ld = 1'b0; v.val = '0; v.dp = '0;
        v.an = 4'b1111; v.dig = 4'h0; v.dpo = 1'b1; v.fd = 1'b0;
        run_vec(v, "post_reset_blank");
        v.n = 2; v.en = 1'b1;
        run_vec(v, "restart_guard");
        v.n = 7; v.an = 4'b1110;
        run_vec(v, "restart_digit0");
        v.n = 1; v.an = 4'b1111;
        run_vec(v, "restart_digit1_guard");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
